// File: rtl/sac_core_pkg.sv
// Shared definitions for the sac_core processor: opcodes, instruction field
// positions, sequencer states and ps_stcky bit indices.
package sac_core_pkg;

  // Opcodes live in op[31:22]
  localparam logic [9:0] OP_NOP    = 10'h000;
  localparam logic [9:0] OP_FINISH = 10'h001;
  localparam logic [9:0] OP_IDLE   = 10'h002;
  localparam logic [9:0] OP_LDI    = 10'h004;
  localparam logic [9:0] OP_ADD    = 10'h005;
  localparam logic [9:0] OP_SUB    = 10'h006;
  localparam logic [9:0] OP_LD     = 10'h008;
  localparam logic [9:0] OP_ST     = 10'h009;
  localparam logic [9:0] OP_JUMP   = 10'h00C;
  localparam logic [9:0] OP_CALL   = 10'h00D;
  localparam logic [9:0] OP_RTS    = 10'h00E;
  localparam logic [9:0] OP_JZ     = 10'h00F;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 22;
  localparam int RD_LSB  = 18;
  localparam int RS1_LSB = 14;
  localparam int RS2_LSB = 10;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  // ps_stcky bit indices
  localparam int STK_EMPTY = 0;
  localparam int STK_FULL  = 1;
  localparam int STK_OVF   = 2;

  // Sequencer states
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/sac_core_if.sv
// Link between the execute datapath (master) and the program sequencer
// (slave): decoded opcode/branch target/Z go one way, PC and run state back.
interface sac_core_if #(
  parameter int PMA = 16
);
  logic [9:0]     opcode;
  logic [PMA-1:0] target;
  logic           z;
  logic [PMA-1:0] pc;
  logic           ps_idle;
  logic           halted;

  modport master (output opcode, output target, output z,
                  input pc, input ps_idle, input halted);
  modport slave  (input opcode, input target, input z,
                  output pc, output ps_idle, output halted);
endinterface

// File: rtl/sac_core_mem.sv
// Program and data memories. Both reads are combinational; DM writes on the
// rising edge. Contents are never reset.
module sac_core_mem #(
  parameter int    PMA_SIZE  = 16,
  parameter int    PMD_SIZE  = 32,
  parameter int    DMA_SIZE  = 16,
  parameter int    DMD_SIZE  = 16,
  parameter string PM_LOCATE = "",
  parameter string DM_LOCATE = ""
) (
  input  logic                clk,
  input  logic [PMA_SIZE-1:0] pc,
  output logic [PMD_SIZE-1:0] pm_ps_op,
  input  logic [DMA_SIZE-1:0] dm_addr,
  output logic [DMD_SIZE-1:0] dm_rdata,
  input  logic                dm_we,
  input  logic [DMD_SIZE-1:0] dm_wdata
);
  logic [PMD_SIZE-1:0] pm [0:2**PMA_SIZE-1];
  logic [DMD_SIZE-1:0] dm [0:2**DMA_SIZE-1];

  assign pm_ps_op = pm[pc];
  assign dm_rdata = dm[dm_addr];

  // Data memory write port
  always_ff @(posedge clk) begin
    if (dm_we) dm[dm_addr] <= dm_wdata;
  end
endmodule

// File: rtl/sac_core_ps.sv
// Program sequencer: PC, return stack, idle/halt state and stack status.
module sac_core_ps
  import sac_core_pkg::*;
#(
  parameter int PMA_SIZE     = 16,
  parameter int SIGNAL_WIDTH = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     interrupt,
  sac_core_if.slave bus
);
  localparam int DEPTH = 2**SIGNAL_WIDTH;
  localparam logic [SIGNAL_WIDTH:0] SP_FULL = (SIGNAL_WIDTH+1)'(DEPTH);

  logic [PMA_SIZE-1:0]     pc_q, pc_d, pc_inc, pc;
  logic [SIGNAL_WIDTH:0]   sp_q, sp_d;
  logic [SIGNAL_WIDTH-1:0] top_idx;
  logic [1:0]              state_q, state_d;
  logic                    ovf_q, ovf_d, push;
  logic [PMA_SIZE-1:0]     stack_q [0:DEPTH-1];
  logic                    ps_idle, halted;
  logic [2:0]              ps_stcky;

  // Next-PC, stack and run-state selection for the instruction at PC
  always_comb begin
    pc_inc  = pc_q + PMA_SIZE'(1);
    top_idx = SIGNAL_WIDTH'(sp_q - 1'b1);
    pc_d    = pc_q;
    sp_d    = sp_q;
    state_d = state_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    case (state_q)
      ST_HALT: ;
      ST_IDLE: begin
        // Only an interrupt sampled while already idle wakes the core
        if (interrupt) begin
          state_d = ST_RUN;
          pc_d    = pc_inc;
        end
      end
      default: begin
        case (bus.opcode)
          OP_FINISH: state_d = ST_HALT;
          OP_IDLE:   state_d = ST_IDLE;
          OP_JUMP:   pc_d = bus.target;
          OP_JZ:     pc_d = bus.z ? bus.target : pc_inc;
          OP_CALL: begin
            // A full stack drops the return address but still branches
            if (sp_q == SP_FULL) begin
              ovf_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + 1'b1;
            end
            pc_d = bus.target;
          end
          OP_RTS: begin
            if (sp_q != '0) begin
              pc_d = stack_q[top_idx];
              sp_d = sp_q - 1'b1;
            end else begin
              pc_d = pc_inc;
            end
          end
          default: pc_d = pc_inc;
        endcase
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      sp_q    <= '0;
      state_q <= ST_RUN;
      ovf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Return-address storage; validity is tracked by sp_q, so no reset needed
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[SIGNAL_WIDTH-1:0]] <= pc_inc;
  end

  // Status outputs derived from state
  always_comb begin
    pc                  = pc_q;
    ps_idle             = (state_q == ST_IDLE);
    halted              = (state_q == ST_HALT);
    ps_stcky            = '0;
    ps_stcky[STK_EMPTY] = (sp_q == '0);
    ps_stcky[STK_FULL]  = (sp_q == SP_FULL);
    ps_stcky[STK_OVF]   = ovf_q;
  end

  assign bus.pc      = pc;
  assign bus.ps_idle = ps_idle;
  assign bus.halted  = halted;
endmodule

// File: rtl/sac_core.sv
// sac_core top: decode, register file and ALU, plus the sequencer and
// memory sub-blocks. One instruction completes per clock.
module sac_core
  import sac_core_pkg::*;
#(
  parameter int    PMA_SIZE      = 16,
  parameter int    PMD_SIZE      = 32,
  parameter int    DMA_SIZE      = 16,
  parameter int    DMD_SIZE      = 16,
  parameter int    RF_DATASIZE   = 16,
  parameter int    ADDRESS_WIDTH = 4,
  parameter int    SIGNAL_WIDTH  = 3,
  parameter string PM_LOCATE     = "",
  parameter string DM_LOCATE     = ""
) (
  input logic clk,
  input logic reset,
  input logic interrupt
);
  localparam int NREG = 2**ADDRESS_WIDTH;

  logic [PMD_SIZE-1:0]      pm_ps_op;
  logic [DMA_SIZE-1:0]      dm_addr;
  logic [DMD_SIZE-1:0]      dm_rdata, dm_wdata;
  logic                     dm_we;
  logic [RF_DATASIZE-1:0]   rf_q [0:NREG-1];
  logic [RF_DATASIZE-1:0]   rf_d [0:NREG-1];
  logic                     z_q, z_d;
  logic [9:0]               opcode;
  logic [ADDRESS_WIDTH-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0]         imm;
  logic [RF_DATASIZE-1:0]   alu_res;
  logic                     exec_en;

  sac_core_if #(.PMA(PMA_SIZE)) ps_bus ();

  assign opcode  = pm_ps_op[OPC_MSB:OPC_LSB];
  assign rd      = pm_ps_op[RD_LSB +: ADDRESS_WIDTH];
  assign rs1     = pm_ps_op[RS1_LSB +: ADDRESS_WIDTH];
  assign rs2     = pm_ps_op[RS2_LSB +: ADDRESS_WIDTH];
  assign imm     = pm_ps_op[IMM_LSB +: IMM_W];
  assign dm_addr = pm_ps_op[IMM_LSB +: DMA_SIZE];

  assign ps_bus.opcode = opcode;
  assign ps_bus.target = pm_ps_op[IMM_LSB +: PMA_SIZE];
  assign ps_bus.z      = z_q;

  // Datapath effects are suppressed while idle, halted or in reset
  assign exec_en  = !ps_bus.halted && !ps_bus.ps_idle && !reset;
  assign dm_wdata = rf_q[rd];

  // Register file / Z-flag next state and store enable
  always_comb begin
    rf_d    = rf_q;
    z_d     = z_q;
    dm_we   = 1'b0;
    alu_res = '0;
    if (exec_en) begin
      case (opcode)
        OP_LDI: rf_d[rd] = RF_DATASIZE'(imm);
        OP_ADD: begin
          alu_res  = rf_q[rs1] + rf_q[rs2];
          rf_d[rd] = alu_res;
          z_d      = (alu_res == '0);
        end
        OP_SUB: begin
          alu_res  = rf_q[rs1] - rf_q[rs2];
          rf_d[rd] = alu_res;
          z_d      = (alu_res == '0);
        end
        OP_LD:   rf_d[rd] = dm_rdata;
        OP_ST:   dm_we = 1'b1;
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

  // Register file and Z flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      z_q <= 1'b0;
    end else begin
      rf_q <= rf_d;
      z_q  <= z_d;
    end
  end

  sac_core_ps #(
    .PMA_SIZE    (PMA_SIZE),
    .SIGNAL_WIDTH(SIGNAL_WIDTH)
  ) ps_obj (
    .clk      (clk),
    .reset    (reset),
    .interrupt(interrupt),
    .bus      (ps_bus)
  );

  sac_core_mem #(
    .PMA_SIZE (PMA_SIZE),
    .PMD_SIZE (PMD_SIZE),
    .DMA_SIZE (DMA_SIZE),
    .DMD_SIZE (DMD_SIZE),
    .PM_LOCATE(PM_LOCATE),
    .DM_LOCATE(DM_LOCATE)
  ) mem_obj (
    .clk     (clk),
    .pc      (ps_bus.pc),
    .pm_ps_op(pm_ps_op),
    .dm_addr (dm_addr),
    .dm_rdata(dm_rdata),
    .dm_we   (dm_we),
    .dm_wdata(dm_wdata)
  );
endmodule

// File: tb/tb_sac_core.sv
// Directed bench for sac_core: small programs are poked into program memory,
// the core is reset, and internal probes are checked after fixed cycle counts.
module tb_sac_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic interrupt = 1'b0;
  int tests = 0;
  int fails = 0;

  localparam logic [9:0] NOP = 10'h000, FIN = 10'h001, IDL = 10'h002, LDI = 10'h004,
                         ADD = 10'h005, SUB = 10'h006, LD = 10'h008, ST = 10'h009,
                         JMP = 10'h00C, CALL = 10'h00D, RTS = 10'h00E, JZ = 10'h00F;

  sac_core dut (.clk(clk), .reset(reset), .interrupt(interrupt));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ei(input logic [9:0] opc, input logic [3:0] rd, input logic [15:0] imm);
    return {opc, rd, 2'b00, imm};
  endfunction

  function automatic logic [31:0] er(input logic [9:0] opc, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    return {opc, rd, rs1, rs2, 10'd0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic put(input logic [15:0] a, input logic [31:0] w);
    dut.mem_obj.pm[a] = w;
  endtask

  task automatic clear_pm();
    for (int i = 0; i < 64; i++) put(16'(i), {NOP, 22'd0});
    put(16'hFFFF, {NOP, 22'd0});
  endtask

  task automatic test_reset();
    clear_pm();
    cyc(5);
    tests++; if (dut.ps_obj.pc !== 16'd5) begin fails++; $display("FAIL nop_advance: pc=%h expected %h", dut.ps_obj.pc, 16'd5); end
    do_reset();
    tests++; if (dut.ps_obj.pc !== 16'd0) begin fails++; $display("FAIL reset_pc: pc=%h expected 0000", dut.ps_obj.pc); end
    tests++; if (dut.ps_obj.ps_stcky !== 3'b001) begin fails++; $display("FAIL reset_stcky: got %b expected 001", dut.ps_obj.ps_stcky); end
    tests++; if (dut.ps_obj.ps_idle !== 1'b0 || dut.ps_obj.halted !== 1'b0) begin fails++; $display("FAIL reset_state: idle=%b halted=%b expected 0 0", dut.ps_obj.ps_idle, dut.ps_obj.halted); end
    tests++; if (dut.z_q !== 1'b0) begin fails++; $display("FAIL reset_z: got %b expected 0", dut.z_q); end
  endtask

  task automatic test_alu();
    clear_pm();
    put(0, ei(LDI, 1, 16'd5));
    put(1, ei(LDI, 2, 16'd3));
    put(2, er(ADD, 3, 1, 2));
    put(3, {FIN, 22'd0});
    do_reset();
    cyc(3);
    tests++; if (dut.rf_q[3] !== 16'd8) begin fails++; $display("FAIL alu_add: r3=%h expected 0008", dut.rf_q[3]); end
    tests++; if (dut.z_q !== 1'b0) begin fails++; $display("FAIL alu_add_z: z=%b expected 0", dut.z_q); end
    tests++; if (dut.ps_obj.pc !== 16'd3 || dut.mem_obj.pm_ps_op[31:22] !== FIN) begin fails++; $display("FAIL finish_fetch: pc=%h op=%h expected 0003 001", dut.ps_obj.pc, dut.mem_obj.pm_ps_op[31:22]); end
    cyc(5);
    tests++; if (dut.ps_obj.pc !== 16'd3 || dut.ps_obj.halted !== 1'b1 || dut.mem_obj.pm_ps_op[31:22] !== FIN) begin fails++; $display("FAIL finish_hold: pc=%h halted=%b op=%h expected 0003 1 001", dut.ps_obj.pc, dut.ps_obj.halted, dut.mem_obj.pm_ps_op[31:22]); end
    do_reset();
    tests++; if (dut.ps_obj.pc !== 16'd0 || dut.ps_obj.halted !== 1'b0 || dut.rf_q[3] !== 16'd0) begin fails++; $display("FAIL reset_from_halt: pc=%h halted=%b r3=%h expected 0000 0 0000", dut.ps_obj.pc, dut.ps_obj.halted, dut.rf_q[3]); end
  endtask

  task automatic test_jz();
    clear_pm();
    put(16'h00, ei(LDI, 1, 16'd5));
    put(16'h01, er(SUB, 4, 1, 1));
    put(16'h02, ei(JZ, 0, 16'h0010));
    put(16'h10, ei(LDI, 2, 16'd3));
    put(16'h11, er(SUB, 5, 1, 2));
    put(16'h12, ei(JZ, 0, 16'h0030));
    put(16'h13, ei(JMP, 0, 16'hFFFF));
    do_reset();
    cyc(2);
    tests++; if (dut.z_q !== 1'b1 || dut.rf_q[4] !== 16'd0) begin fails++; $display("FAIL sub_zero: z=%b r4=%h expected 1 0000", dut.z_q, dut.rf_q[4]); end
    cyc(1);
    tests++; if (dut.ps_obj.pc !== 16'h0010) begin fails++; $display("FAIL jz_taken: pc=%h expected 0010", dut.ps_obj.pc); end
    cyc(2);
    tests++; if (dut.z_q !== 1'b0 || dut.rf_q[5] !== 16'd2) begin fails++; $display("FAIL sub_nonzero: z=%b r5=%h expected 0 0002", dut.z_q, dut.rf_q[5]); end
    cyc(1);
    tests++; if (dut.ps_obj.pc !== 16'h0013) begin fails++; $display("FAIL jz_not_taken: pc=%h expected 0013", dut.ps_obj.pc); end
    cyc(1);
    tests++; if (dut.ps_obj.pc !== 16'hFFFF) begin fails++; $display("FAIL jump: pc=%h expected ffff", dut.ps_obj.pc); end
    cyc(1);
    tests++; if (dut.ps_obj.pc !== 16'h0000) begin fails++; $display("FAIL pc_wrap: pc=%h expected 0000", dut.ps_obj.pc); end
  endtask

  task automatic test_mem();
    clear_pm();
    put(0, ei(LDI, 3, 16'd8));
    put(1, ei(ST, 3, 16'h0020));
    put(2, ei(LDI, 7, 16'hABCD));
    put(3, ei(ST, 7, 16'h0021));
    put(4, ei(LD, 5, 16'h0020));
    put(5, ei(LD, 6, 16'h0021));
    put(6, {FIN, 22'd0});
    do_reset();
    cyc(2);
    tests++; if (dut.mem_obj.dm[16'h20] !== 16'd8) begin fails++; $display("FAIL store: dm[20]=%h expected 0008", dut.mem_obj.dm[16'h20]); end
    cyc(4);
    tests++; if (dut.mem_obj.dm[16'h21] !== 16'hABCD) begin fails++; $display("FAIL store2: dm[21]=%h expected abcd", dut.mem_obj.dm[16'h21]); end
    tests++; if (dut.rf_q[5] !== 16'd8 || dut.rf_q[6] !== 16'hABCD) begin fails++; $display("FAIL load: r5=%h r6=%h expected 0008 abcd", dut.rf_q[5], dut.rf_q[6]); end
  endtask

  task automatic test_idle();
    clear_pm();
    put(0, ei(LDI, 1, 16'd1));
    put(1, {IDL, 22'd0});
    put(2, ei(LDI, 2, 16'h0055));
    put(3, {FIN, 22'd0});
    do_reset();
    interrupt = 1'b1;
    cyc(2);
    interrupt = 1'b0;
    tests++; if (dut.ps_obj.ps_idle !== 1'b1 || dut.ps_obj.pc !== 16'd1) begin fails++; $display("FAIL idle_enter: idle=%b pc=%h expected 1 0001", dut.ps_obj.ps_idle, dut.ps_obj.pc); end
    cyc(10);
    tests++; if (dut.ps_obj.ps_idle !== 1'b1 || dut.ps_obj.pc !== 16'd1 || dut.rf_q[2] !== 16'd0) begin fails++; $display("FAIL idle_hold: idle=%b pc=%h r2=%h expected 1 0001 0000", dut.ps_obj.ps_idle, dut.ps_obj.pc, dut.rf_q[2]); end
    interrupt = 1'b1;
    cyc(1);
    interrupt = 1'b0;
    tests++; if (dut.ps_obj.ps_idle !== 1'b0 || dut.ps_obj.pc !== 16'd2) begin fails++; $display("FAIL idle_wake: idle=%b pc=%h expected 0 0002", dut.ps_obj.ps_idle, dut.ps_obj.pc); end
    cyc(1);
    tests++; if (dut.rf_q[2] !== 16'h0055 || dut.ps_obj.pc !== 16'd3) begin fails++; $display("FAIL after_wake: r2=%h pc=%h expected 0055 0003", dut.rf_q[2], dut.ps_obj.pc); end
  endtask

  task automatic test_overflow();
    clear_pm();
    for (int i = 0; i < 9; i++) put(16'(i), ei(CALL, 0, 16'(i + 1)));
    put(9, {FIN, 22'd0});
    do_reset();
    cyc(1);
    tests++; if (dut.ps_obj.ps_stcky !== 3'b000) begin fails++; $display("FAIL stack_one: stcky=%b expected 000", dut.ps_obj.ps_stcky); end
    cyc(7);
    tests++; if (dut.ps_obj.ps_stcky !== 3'b010 || dut.ps_obj.pc !== 16'd8) begin fails++; $display("FAIL stack_full: stcky=%b pc=%h expected 010 0008", dut.ps_obj.ps_stcky, dut.ps_obj.pc); end
    cyc(1);
    tests++; if (dut.ps_obj.ps_stcky !== 3'b110 || dut.ps_obj.pc !== 16'd9) begin fails++; $display("FAIL stack_ovf: stcky=%b pc=%h expected 110 0009", dut.ps_obj.ps_stcky, dut.ps_obj.pc); end
    do_reset();
    tests++; if (dut.ps_obj.ps_stcky !== 3'b001) begin fails++; $display("FAIL ovf_reset: stcky=%b expected 001", dut.ps_obj.ps_stcky); end
  endtask

  task automatic test_call_rts();
    clear_pm();
    put(16'h00, ei(CALL, 0, 16'h0010));
    put(16'h01, {RTS, 22'd0});
    put(16'h02, {FIN, 22'd0});
    put(16'h10, ei(LDI, 8, 16'h1234));
    put(16'h11, {RTS, 22'd0});
    do_reset();
    cyc(1);
    tests++; if (dut.ps_obj.pc !== 16'h0010 || dut.ps_obj.ps_stcky !== 3'b000) begin fails++; $display("FAIL call: pc=%h stcky=%b expected 0010 000", dut.ps_obj.pc, dut.ps_obj.ps_stcky); end
    cyc(2);
    tests++; if (dut.ps_obj.pc !== 16'h0001 || dut.ps_obj.ps_stcky !== 3'b001 || dut.rf_q[8] !== 16'h1234) begin fails++; $display("FAIL rts: pc=%h stcky=%b r8=%h expected 0001 001 1234", dut.ps_obj.pc, dut.ps_obj.ps_stcky, dut.rf_q[8]); end
    cyc(1);
    tests++; if (dut.ps_obj.pc !== 16'h0002 || dut.ps_obj.ps_stcky !== 3'b001) begin fails++; $display("FAIL rts_empty: pc=%h stcky=%b expected 0002 001", dut.ps_obj.pc, dut.ps_obj.ps_stcky); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_alu();
    test_jz();
    test_mem();
    test_idle();
    test_overflow();
    test_call_rts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
